// File: rtl/retospect_bs_loader.sv
// rtl/retospect_bs_loader.sv - byte-stream to config shift-chain loader
//
// Accepts configuration bytes over a valid/ready handshake. It shifts them
// LSB-first onto the config_en/bs_in daisy chain, pulses reset_nn and then
// signals done.
//
// Optional feature macro: RETOSPECT_BS_READBACK_EN
//   When this macro is defined, each bs_out bit that leaves the chain while
//   config_en is high is folded into a CRC-8 (poly 0x07, init 0x00, MSB-first).
//   When it is undefined, readback_crc is tied to zero.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             begin a load (sampled only in IDLE)
//   byte_data/valid   configuration byte in, LSB shifted first
//   byte_ready        loader accepts a byte this cycle
//   config_en, bs_in  shift enable and serial data to the chain
//   bs_out            chain tail output (old configuration)
//   reset_nn          potential-preload pulse after the last bit
//   busy, done        load in progress / one-cycle completion pulse
//   bit_count         bits shifted in the current load
//   readback_crc      CRC-8 of the bits read back from bs_out
module retospect_bs_loader #(
  parameter int CHAIN_BITS    = 1378,
  parameter int NN_RST_CYCLES = 2,
  parameter int CNT_W         = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             config_en,
  output logic             bs_in,
  input  logic             bs_out,
  output logic             reset_nn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [7:0]       readback_crc
);

  localparam logic [CNT_W-1:0] CHAIN_L = CNT_W'(CHAIN_BITS);
  localparam int               NN_W    = (NN_RST_CYCLES > 1) ? $clog2(NN_RST_CYCLES) : 1;
  localparam logic [NN_W-1:0]  NN_LAST = NN_W'(NN_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    NNRST = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  // shreg holds the bits still to come after the one currently on bs_in;
  // bits_left counts them. This allows every output to be registered while
  // the first bit still appears in the cycle right after the handshake.
  logic [6:0]       shreg_q, shreg_d;
  logic [2:0]       bits_left_q, bits_left_d;
  logic [NN_W-1:0]  nn_cnt_q, nn_cnt_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [CNT_W-1:0] remain;
  logic             byte_ready_q, byte_ready_d;
  logic             config_en_q, config_en_d;
  logic             bs_in_q, bs_in_d;
  logic             reset_nn_q, reset_nn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign remain = CHAIN_L - bit_count_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    nn_cnt_d    = nn_cnt_q;
    bit_count_d = bit_count_q;
    bs_in_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bit_count_d = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (byte_valid && byte_ready_q) begin
          bs_in_d = byte_data[0];
          shreg_d = byte_data[7:1];
          // A final partial byte shifts only the bits the chain still needs.
          // Its unused high bits are left behind in shreg.
          bits_left_d = (remain >= CNT_W'(8)) ? 3'd7 : 3'(remain - CNT_W'(1));
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        bit_count_d = bit_count_q + CNT_W'(1);
        if (bits_left_q != 3'd0) begin
          bs_in_d     = shreg_q[0];
          shreg_d     = {1'b0, shreg_q[6:1]};
          bits_left_d = bits_left_q - 3'd1;
        end else if (bit_count_q + CNT_W'(1) == CHAIN_L) begin
          nn_cnt_d = '0;
          state_d  = NNRST;
        end else begin
          state_d = LOAD;
        end
      end
      NNRST: begin
        nn_cnt_d = nn_cnt_q + NN_W'(1);
        if (nn_cnt_q == NN_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // All outputs are decoded from the next state so that they register
    // with the state itself.
    byte_ready_d = (state_d == LOAD);
    config_en_d  = (state_d == SHIFT);
    reset_nn_d   = (state_d == NNRST);
    busy_d       = (state_d == LOAD) || (state_d == SHIFT) || (state_d == NNRST);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bits_left_q  <= '0;
      nn_cnt_q     <= '0;
      bit_count_q  <= '0;
      byte_ready_q <= 1'b0;
      config_en_q  <= 1'b0;
      bs_in_q      <= 1'b0;
      reset_nn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bits_left_q  <= bits_left_d;
      nn_cnt_q     <= nn_cnt_d;
      bit_count_q  <= bit_count_d;
      byte_ready_q <= byte_ready_d;
      config_en_q  <= config_en_d;
      bs_in_q      <= bs_in_d;
      reset_nn_q   <= reset_nn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign config_en  = config_en_q;
  assign bs_in      = bs_in_q;
  assign reset_nn   = reset_nn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_count  = bit_count_q;

`ifdef RETOSPECT_BS_READBACK_EN
  logic [7:0] crc_q, crc_d;

  // The chain shifts on every cycle where config_en is high. In that same
  // cycle, bs_out carries the old tail bit that is leaving the chain.
  always_comb begin
    crc_d = crc_q;
    if ((state_q == IDLE) && start) begin
      crc_d = 8'h00;
    end else if (config_en_q) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bs_out) ? 8'h07 : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_bs_out;
  assign unused_bs_out = bs_out;
  assign readback_crc  = 8'h00;
`endif

endmodule

// File: tb/tb_retospect_bs_loader.sv
// tb/tb_retospect_bs_loader.sv - self-checking bench for retospect_bs_loader
module tb_retospect_bs_loader;

  localparam int NA = 10;
  localparam int NB = 1378;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_valid = 1'b0;
  logic bs_out = 1'b0;

  logic rdy_a, cen_a, bsin_a, rnn_a, busy_a, done_a;
  logic rdy_b, cen_b, bsin_b, rnn_b, busy_b, done_b;
  logic [10:0] cnt_a, cnt_b;
  logic [7:0] crc_a, crc_b;
  logic start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  always #5 clk = ~clk;

  retospect_bs_loader #(.CHAIN_BITS(NA), .NN_RST_CYCLES(2), .CNT_W(11)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(rdy_a), .config_en(cen_a),
    .bs_in(bsin_a), .bs_out(bs_out), .reset_nn(rnn_a), .busy(busy_a),
    .done(done_a), .bit_count(cnt_a), .readback_crc(crc_a)
  );

  retospect_bs_loader #(.CHAIN_BITS(NB), .NN_RST_CYCLES(2), .CNT_W(11)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(rdy_b), .config_en(cen_b),
    .bs_in(bsin_b), .bs_out(bs_out), .reset_nn(rnn_b), .busy(busy_b),
    .done(done_b), .bit_count(cnt_b), .readback_crc(crc_b)
  );

  logic rdy_m, cen_m, bsin_m, rnn_m, busy_m, done_m;
  logic [10:0] cnt_m;
  logic [7:0] crc_m;
  assign rdy_m  = sel ? rdy_b  : rdy_a;
  assign cen_m  = sel ? cen_b  : cen_a;
  assign bsin_m = sel ? bsin_b : bsin_a;
  assign rnn_m  = sel ? rnn_b  : rnn_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign cnt_m  = sel ? cnt_b  : cnt_a;
  assign crc_m  = sel ? crc_b  : crc_a;

  int vectors = 0;
  int miscompares = 0;
  int cen_cnt, nn_cnt, done_cnt, overlap, acc_cnt;
  bit got_q[$];
  bit rb_q[$];
  logic [7:0] byte_mem [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe the chain interface away from the active edge.
  always @(negedge clk) begin
    if (cen_m) begin
      got_q.push_back(bsin_m);
      rb_q.push_back(bs_out);
      cen_cnt++;
    end
    if (rnn_m) nn_cnt++;
    if (done_m) done_cnt++;
    if (cen_m && rnn_m) overlap++;
    if (rdy_m && byte_valid) acc_cnt++;
  end

  // Stream bit k is bit k%8 of byte k/8.
  function automatic bit exp_bit(input int k);
    logic [7:0] b;
    b = byte_mem[k / 8];
    return b[k % 8];
  endfunction

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input int n);
    logic [63:0] rem;
    rem = 64'h0;
    for (int i = 0; i < n; i++) rem = (rem << 1) | 64'(rb_q[i]);
    rem = rem << 8;
    for (int b = n + 7; b >= 8; b--) begin
      if (rem[b]) rem = rem ^ (64'h107 << (b - 8));
    end
    return rem[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int nbytes, input bit stall, input bit poke, input bit extra);
    int len;
    int t;
    int nbad;
    logic [7:0] exp_crc;
    len = sel ? NB : NA;
    got_q.delete();
    rb_q.delete();
    cen_cnt = 0; nn_cnt = 0; done_cnt = 0; overlap = 0; acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cnt0", 32'(cnt_m), 0);
    chk("start_rdy", 32'(rdy_m), 1);
    for (int i = 0; i < nbytes; i++) begin
      byte_data = byte_mem[i];
      byte_valid = 1'b1;
      t = 0;
      while (!rdy_m && t < 64) begin
        tick();
        t++;
      end
      if (t >= 64) chk("rdy_timeout", 1, 0);
      tick();
      if (extra && i == nbytes - 1) byte_data = 8'hFF;
      else byte_valid = 1'b0;
      if (poke && i == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (stall && i < nbytes - 1) begin
        t = 0;
        while (!rdy_m && t < 64) begin
          tick();
          t++;
        end
        for (int s = 0; s < 5; s++) begin
          chk("stall_cen", 32'(cen_m), 0);
          chk("stall_rdy", 32'(rdy_m), 1);
          tick();
        end
      end
    end
    t = 0;
    while (!done_m && t < 2 * len + 64) begin
      tick();
      t++;
    end
    chk("done_seen", 32'(done_m), 1);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat (3) tick();
    chk("cen_cycles", 32'(cen_cnt), 32'(len));
    chk("seq_len", 32'(got_q.size()), 32'(len));
    nbad = 0;
    for (int k = 0; k < got_q.size() && k < len; k++) begin
      if (got_q[k] !== exp_bit(k)) nbad++;
    end
    chk("seq_bits_bad", 32'(nbad), 0);
    chk("bit_count", 32'(cnt_m), 32'(len));
    chk("nn_cycles", 32'(nn_cnt), 2);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("cen_rnn_overlap", 32'(overlap), 0);
    chk("busy_after", 32'(busy_m), 0);
    chk("rdy_after", 32'(rdy_m), 0);
    chk("bytes_accepted", 32'(acc_cnt), 32'(nbytes));
    if (!sel) begin
`ifdef RETOSPECT_BS_READBACK_EN
      exp_crc = crc_model(rb_q.size());
`else
      exp_crc = 8'h00;
`endif
      chk("readback_crc", 32'(crc_m), 32'(exp_crc));
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] got_v;
    logic [9:0] lit;
    int t;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy_a), 0);
    chk("rst_cen", 32'(cen_a), 0);
    chk("rst_bsin", 32'(bsin_a), 0);
    chk("rst_rnn", 32'(rnn_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_crc", 32'(crc_a), 0);
    reset = 1'b0;
    tick();

    // full load: 0xA5, 0x03
    byte_mem[0] = 8'hA5;
    byte_mem[1] = 8'h03;
    run_load(2, 1'b0, 1'b0, 1'b0);
    got_v = '0;
    for (int k = 0; k < got_q.size() && k < 10; k++) got_v[k] = got_q[k];
    lit = 10'b11_1010_0101;
    chk("seq_literal", 32'(got_v), 32'(lit));

    // stall between bytes
    run_load(2, 1'b1, 1'b0, 1'b0);

    // randomized loads
    for (int r = 0; r < 4; r++) begin
      byte_mem[0] = 8'($urandom);
      byte_mem[1] = 8'($urandom);
      bs_out = 1'($urandom_range(0, 1));
      run_load(2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // start pulsed during SHIFT and during DONE
    bs_out = 1'b0;
    run_load(2, 1'b0, 1'b1, 1'b0);

    // readback with bs_out held high
    bs_out = 1'b1;
    run_load(2, 1'b0, 1'b0, 1'b0);
    bs_out = 1'b0;

    // reset mid-SHIFT
    start = 1'b1;
    tick();
    start = 1'b0;
    cen_cnt = 0;
    byte_data = 8'h5A;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    t = 0;
    while (cen_cnt < 4 && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("bits_before_rst", 32'(cen_cnt), 4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cen", 32'(cen_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_rnn", 32'(rnn_a), 0);
    chk("arst_rdy", 32'(rdy_a), 0);
    chk("arst_cnt", 32'(cnt_a), 0);
    tick();
    reset = 1'b0;
    tick();
    byte_mem[0] = 8'($urandom);
    byte_mem[1] = 8'($urandom);
    run_load(2, 1'b0, 1'b0, 1'b0);

    // default chain length: 173 bytes, last one partial, 174th refused
    sel = 1'b1;
    for (int i = 0; i < 172; i++) byte_mem[i] = 8'($urandom);
    byte_mem[172] = 8'hFC | 8'($urandom_range(0, 3));
    run_load(173, 1'b0, 1'b0, 1'b1);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
